// File: rtl/noc_packet_tx.sv
// NoC packet transmitter: emits a header flit, then forwards up to MAX_LEN payload
// words onto a selected virtual channel, with per-VC valid/ready handshaking.
module noc_packet_tx #(
    parameter int FLIT_WIDTH = 32,
    parameter int VCHANNELS  = 1,
    parameter int DEST_WIDTH = 5,
    parameter int SRC_ID     = 0,
    parameter int MAX_LEN    = 8,
    localparam int VCW       = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DEST_WIDTH-1:0] req_dest,
    input  logic [VCW-1:0]        req_vc,
    input  logic [7:0]            req_len,
    input  logic [FLIT_WIDTH-1:0] data_flit,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic [VCHANNELS-1:0]  out_valid,
    input  logic [VCHANNELS-1:0]  out_ready,
    output logic                  len_err
);

    localparam logic [7:0] MAX_L = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t                state;
    logic [DEST_WIDTH-1:0] dest;
    logic [VCW-1:0]        vc;
    logic [7:0]            len;
    logic [7:0]            cnt;
    logic                  sel_ready;
    logic                  flit_valid;
    logic [FLIT_WIDTH-1:0] header;

    always_comb begin
        header = '0;
        header[FLIT_WIDTH-1 -: DEST_WIDTH] = dest;
        header[15:8] = 8'(SRC_ID);
        header[7:0]  = len;
    end

    // Only the selected VC's ready is observed; other VCs are ignored.
    always_comb begin
        sel_ready = 1'b0;
        for (int unsigned i = 0; i < VCHANNELS; i++) begin
            if (vc == VCW'(i)) sel_ready = out_ready[i];
        end
    end

    // Outputs are gated by rst so nothing is emitted or consumed in a reset cycle.
    always_comb begin
        req_ready  = (state == IDLE);
        out_flit   = '0;
        out_last   = 1'b0;
        flit_valid = 1'b0;
        data_ready = 1'b0;
        case (state)
            HEADER: begin
                out_flit   = header;
                out_last   = rst && (len == 8'd0);
                flit_valid = rst;
            end
            PAYLOAD: begin
                out_flit   = data_flit;
                out_last   = rst && (cnt == len - 8'd1);
                flit_valid = rst && data_valid;
                data_ready = rst && sel_ready;
            end
            default: ;
        endcase
        out_valid = '0;
        for (int unsigned i = 0; i < VCHANNELS; i++) begin
            out_valid[i] = flit_valid && (vc == VCW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            dest    <= '0;
            vc      <= '0;
            len     <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dest  <= req_dest;
                        vc    <= req_vc;
                        len   <= (req_len > MAX_L) ? MAX_L : req_len;
                        state <= HEADER;
                        if (req_len > MAX_L) len_err <= 1'b1;
                    end
                end
                HEADER: begin
                    if (sel_ready) begin
                        cnt   <= '0;
                        state <= (len == 8'd0) ? IDLE : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (data_valid && sel_ready) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len - 8'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_packet_tx.sv
// Directed self-checking bench for noc_packet_tx with two virtual channels.
module tb_noc_packet_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_dest;
    logic [0:0]  req_vc;
    logic [7:0]  req_len;
    logic [31:0] data_flit;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic        len_err;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    noc_packet_tx #(
        .FLIT_WIDTH(32),
        .VCHANNELS (2),
        .DEST_WIDTH(5),
        .SRC_ID    (0),
        .MAX_LEN   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest  (req_dest),
        .req_vc    (req_vc),
        .req_len   (req_len),
        .data_flit (data_flit),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input logic exp_err);
        @(negedge clk);
        req_valid = 1'b0;
        data_valid = 1'b1;
        #1;
        check("idle_req_ready", req_ready, 1'b1);
        check("idle_out_valid", out_valid, 2'b00);
        check("idle_data_ready", data_ready, 1'b0);
        check("idle_len_err", len_err, exp_err);
    endtask

    task automatic send_req(input logic [4:0] d, input logic v, input logic [7:0] l);
        @(negedge clk);
        req_valid = 1'b1;
        req_dest  = d;
        req_vc    = v;
        req_len   = l;
        #1;
        check("req_ready", req_ready, 1'b1);
    endtask

    task automatic hdr_beat(input logic [31:0] exp_flit, input logic [1:0] exp_valid,
                            input logic exp_last, input logic [1:0] ordy);
        @(negedge clk);
        req_valid  = 1'b0;
        data_valid = 1'b1;
        out_ready  = ordy;
        #1;
        check("hdr_flit", out_flit, exp_flit);
        check("hdr_valid", out_valid, exp_valid);
        check("hdr_last", out_last, exp_last);
        check("hdr_data_ready", data_ready, 1'b0);
        check("hdr_req_ready", req_ready, 1'b0);
    endtask

    task automatic pay_beat(input logic [31:0] flit, input logic dv, input logic [1:0] ordy,
                            input logic [1:0] exp_valid, input logic exp_dr, input logic exp_last);
        @(negedge clk);
        data_flit  = flit;
        data_valid = dv;
        out_ready  = ordy;
        #1;
        check("pay_flit", out_flit, flit);
        check("pay_valid", out_valid, exp_valid);
        check("pay_data_ready", data_ready, exp_dr);
        if (exp_valid != 2'b00) check("pay_last", out_last, exp_last);
    endtask

    // Stall pattern for the back-pressure packet on vc 1: {data_valid, out_ready}
    logic [2:0] stall_tab [9] = '{3'b1_00, 3'b0_10, 3'b1_10, 3'b1_01, 3'b1_10,
                                  3'b0_00, 3'b1_10, 3'b1_00, 3'b1_10};

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        int unsigned sent;
        rst = 1'b0; req_valid = 1'b0; req_dest = '0; req_vc = '0; req_len = '0;
        data_flit = '0; data_valid = 1'b0; out_ready = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_out_valid", out_valid, 2'b00);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_flit", out_flit, 32'h0);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        rst = 1'b1;

        // dest=5, len=3, always ready
        send_req(5'd5, 1'b0, 8'd3);
        hdr_beat(32'h2800_0003, 2'b01, 1'b0, 2'b11);
        pay_beat(32'hA0, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
        pay_beat(32'hA1, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
        pay_beat(32'hA2, 1'b1, 2'b11, 2'b01, 1'b1, 1'b1);
        idle_check(1'b0);

        // zero-length packet
        send_req(5'd9, 1'b0, 8'd0);
        hdr_beat(32'h4800_0000, 2'b01, 1'b1, 2'b11);
        idle_check(1'b0);

        // len=4 on vc 1 with header stall and payload gaps
        send_req(5'd31, 1'b1, 8'd4);
        hdr_beat(32'hF800_0004, 2'b10, 1'b0, 2'b00);
        hdr_beat(32'hF800_0004, 2'b10, 1'b0, 2'b00);
        hdr_beat(32'hF800_0004, 2'b10, 1'b0, 2'b01);
        hdr_beat(32'hF800_0004, 2'b10, 1'b0, 2'b11);
        sent = 0;
        for (int i = 0; i < 9; i++) begin
            logic dv;
            logic [1:0] ordy;
            dv   = stall_tab[i][2];
            ordy = stall_tab[i][1:0];
            pay_beat(32'hC0 + sent, dv, ordy, dv ? 2'b10 : 2'b00, ordy[1], sent == 3);
            if (dv && ordy[1]) sent++;
        end
        check("stall_payload_count", 64'(sent), 64'd4);
        idle_check(1'b0);

        // vc 1 selected, ready only on vc 0: no progress
        send_req(5'd2, 1'b1, 8'd1);
        for (int i = 0; i < 4; i++) hdr_beat(32'h1000_0001, 2'b10, 1'b0, 2'b01);
        hdr_beat(32'h1000_0001, 2'b10, 1'b0, 2'b10);
        pay_beat(32'hD0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1);
        idle_check(1'b0);

        // oversize request truncated to MAX_LEN
        send_req(5'd1, 1'b0, 8'd20);
        hdr_beat(32'h0800_0008, 2'b01, 1'b0, 2'b11);
        for (int i = 0; i < 8; i++) pay_beat(32'hE0 + i, 1'b1, 2'b11, 2'b01, 1'b1, i == 7);
        idle_check(1'b1);

        // reset after the 2nd of 5 payloads
        send_req(5'd4, 1'b0, 8'd5);
        hdr_beat(32'h2000_0005, 2'b01, 1'b0, 2'b11);
        pay_beat(32'hB0, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
        pay_beat(32'hB1, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
        check("pre_rst_len_err", len_err, 1'b1);
        @(negedge clk);
        rst = 1'b0; data_flit = 32'hB2; data_valid = 1'b1; out_ready = 2'b11;
        #1;
        check("rst_cycle_data_ready", data_ready, 1'b0);
        check("rst_cycle_out_valid", out_valid, 2'b00);
        @(negedge clk);
        #1;
        check("post_rst_out_valid", out_valid, 2'b00);
        check("post_rst_req_ready", req_ready, 1'b1);
        check("post_rst_out_flit", out_flit, 32'h0);
        rst = 1'b1;
        idle_check(1'b0);
        send_req(5'd3, 1'b0, 8'd1);
        hdr_beat(32'h1800_0001, 2'b01, 1'b0, 2'b11);
        pay_beat(32'hF0, 1'b1, 2'b11, 2'b01, 1'b1, 1'b1);
        idle_check(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
